// File: rtl/fact_req_ctrl.sv
// Request/response front end for a multi-cycle factorial unit: one job at a
// time, with a WAIT-state timeout and a count of consumed responses.
module fact_req_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_n,
    output logic [7:0]       fact_n,
    output logic             fact_go,
    input  logic             fact_done,
    input  logic             fact_err,
    input  logic [31:0]      fact_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] job_count
);

    localparam int unsigned TMR_W = 16;
    localparam int unsigned DAT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         n_q, n_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [DAT_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               finish_c;
    logic               expire_c;

    assign finish_c = fact_done | fact_err;
    assign expire_c = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    // State and job registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            timer_q       <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            timer_q       <= timer_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next state; completion takes priority over a coincident timeout
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        timer_d       = timer_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    n_d     = req_n;
                    state_d = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (finish_c) begin
                    rsp_err_d     = fact_err;
                    rsp_data_d    = fact_err ? '0 : fact_result;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (expire_c) begin
                    rsp_err_d     = 1'b0;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        req_ready = 1'b0;
        fact_go   = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_START: fact_go   = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign fact_n      = n_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign job_count   = cnt_q;

endmodule

// File: tb/tb_fact_req_ctrl.sv
// Directed bench for fact_req_ctrl: table of factorial jobs against a unit
// model finishing 2+n cycles after fact_go, plus stall, reset and timeout runs.
module tb_fact_req_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_n, fact_n;
    logic        fact_go, fact_done, fact_err;
    logic [31:0] fact_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err, rsp_timeout, busy;
    logic [15:0] job_count;

    logic        to_req_valid, to_req_ready;
    logic [7:0]  to_req_n, to_fact_n;
    logic        to_fact_go, to_fact_done, to_fact_err;
    logic [31:0] to_fact_result;
    logic        to_rsp_valid, to_rsp_ready;
    logic [31:0] to_rsp_data;
    logic        to_rsp_err, to_rsp_timeout, to_busy;
    logic [15:0] to_job_count;

    int checks;
    int failures;
    int exp_jobs;

    fact_req_ctrl #(.TIMEOUT_CYC(1024), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
        .fact_n(fact_n), .fact_go(fact_go), .fact_done(fact_done),
        .fact_err(fact_err), .fact_result(fact_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .job_count(job_count)
    );

    fact_req_ctrl #(.TIMEOUT_CYC(8), .CNT_W(16)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(to_req_valid), .req_ready(to_req_ready), .req_n(to_req_n),
        .fact_n(to_fact_n), .fact_go(to_fact_go), .fact_done(to_fact_done),
        .fact_err(to_fact_err), .fact_result(to_fact_result),
        .rsp_valid(to_rsp_valid), .rsp_ready(to_rsp_ready), .rsp_data(to_rsp_data),
        .rsp_err(to_rsp_err), .rsp_timeout(to_rsp_timeout), .busy(to_busy),
        .job_count(to_job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input logic [7:0] n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    // Factorial unit model: errors on n>12, otherwise n! after 2+n cycles
    int         mdl_cnt;
    logic       mdl_act;
    logic [7:0] mdl_n;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_act     <= 1'b0;
            mdl_cnt     <= 0;
            mdl_n       <= '0;
            fact_done   <= 1'b0;
            fact_err    <= 1'b0;
            fact_result <= '0;
        end else begin
            fact_done <= 1'b0;
            fact_err  <= 1'b0;
            if (fact_go) begin
                mdl_act <= 1'b1;
                mdl_cnt <= 2 + int'(fact_n);
                mdl_n   <= fact_n;
            end else if (mdl_act) begin
                if (mdl_cnt <= 1) begin
                    mdl_act <= 1'b0;
                    if (mdl_n > 8'd12) begin
                        fact_err    <= 1'b1;
                        fact_result <= 32'hDEAD_BEEF;
                    end else begin
                        fact_done   <= 1'b1;
                        fact_result <= fact(mdl_n);
                    end
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One full job on the main instance, including latency and handshake checks
    task automatic run_job(input logic [7:0] n, input logic [31:0] ed, input logic ee);
        int gos;
        int cyc;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        req_n     = n;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("start_go", 32'(fact_go), 32'd1);
        chk("start_req_ready", 32'(req_ready), 32'd0);
        chk("start_fact_n", 32'(fact_n), 32'(n));
        gos = 1;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            cyc++;
            if (fact_go) gos++;
            if (rsp_valid) break;
        end
        chk("rsp_arrived", 32'(rsp_valid), 32'd1);
        chk("rsp_latency", 32'(cyc), 32'(int'(n) + 4));
        chk("go_pulses", 32'(gos), 32'd1);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_jobs++;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("job_count", 32'(job_count), 32'(exp_jobs));
    endtask

    typedef struct {
        logic [7:0]  n;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        checks    = 0;
        failures  = 0;
        exp_jobs  = 0;
        req_valid = 1'b0;
        req_n     = '0;
        rsp_ready = 1'b0;
        to_req_valid   = 1'b0;
        to_req_n       = '0;
        to_fact_done   = 1'b0;
        to_fact_err    = 1'b0;
        to_fact_result = '0;
        to_rsp_ready   = 1'b0;

        vecs[0] = '{n: 8'd5,  data: 32'd120,       err: 1'b0};
        vecs[1] = '{n: 8'd0,  data: 32'd1,         err: 1'b0};
        vecs[2] = '{n: 8'd12, data: 32'd479001600, err: 1'b0};
        vecs[3] = '{n: 8'd13, data: 32'd0,         err: 1'b1};
        vecs[4] = '{n: 8'd1,  data: 32'd1,         err: 1'b0};
        vecs[5] = '{n: 8'd7,  data: 32'd5040,      err: 1'b0};

        rst = 1'b1;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_fact_go", 32'(fact_go), 32'd0);
        chk("rst_job_count", 32'(job_count), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_job(vecs[i].n, vecs[i].data, vecs[i].err);

        // Response back-pressure with a pending request that must not be taken
        req_n     = 8'd4;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) break;
            step();
        end
        req_valid = 1'b1;
        req_n     = 8'd9;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", rsp_data, 32'd24);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_jobs++;
        chk("stall_done_valid", 32'(rsp_valid), 32'd0);
        chk("stall_done_ready", 32'(req_ready), 32'd1);
        chk("stall_job_count", 32'(job_count), 32'(exp_jobs));
        chk("stall_fact_n", 32'(fact_n), 32'd4);

        // Asynchronous reset during WAIT discards the job
        req_n     = 8'd7;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd1);
        chk("async_rst_count", 32'(job_count), 32'd0);
        chk("async_rst_fact_n", 32'(fact_n), 32'd0);
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        step();
        rst = 1'b0;
        exp_jobs = 0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                step();
                if (rsp_valid) seen++;
            end
            chk("no_rsp_after_rst", 32'(seen), 32'd0);
        end
        run_job(8'd3, 32'd6, 1'b0);

        // Timeout instance: expiry exactly 8 cycles after WAIT entry
        to_req_n     = 8'd9;
        to_req_valid = 1'b1;
        step();
        to_req_valid = 1'b0;
        chk("to_go", 32'(to_fact_go), 32'd1);
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_not_yet", 32'(to_rsp_valid), 32'd0);
        end
        step();
        chk("to_valid", 32'(to_rsp_valid), 32'd1);
        chk("to_timeout", 32'(to_rsp_timeout), 32'd1);
        chk("to_data", to_rsp_data, 32'd0);
        chk("to_err", 32'(to_rsp_err), 32'd0);
        to_rsp_ready = 1'b1;
        step();
        to_rsp_ready = 1'b0;
        chk("to_count", 32'(to_job_count), 32'd1);

        // Completion coinciding with expiry wins
        to_req_valid = 1'b1;
        step();
        to_req_valid = 1'b0;
        step();
        for (int i = 0; i < 7; i++) step();
        to_fact_done   = 1'b1;
        to_fact_result = 32'd77;
        step();
        to_fact_done = 1'b0;
        chk("tie_valid", 32'(to_rsp_valid), 32'd1);
        chk("tie_timeout", 32'(to_rsp_timeout), 32'd0);
        chk("tie_data", to_rsp_data, 32'd77);
        to_rsp_ready = 1'b1;
        step();
        to_rsp_ready = 1'b0;
        chk("tie_count", 32'(to_job_count), 32'd2);
        chk("tie_busy", 32'(to_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fact_req_ctrl.md
FACT_REQ_CTRL -- requirements
Module: fact_req_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- TIMEOUT_CYC, 1024: cycles allowed in WAIT before a job aborts (legal range 2..65535).
- CNT_W, 16: width of the completed-job counter.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high with req_valid.
- req_n  in  8  operand n.
- fact_n  out  8  operand to the factorial unit.
- fact_go  out  1  start strobe to the factorial unit.
- fact_done  in  1  factorial unit finished.
- fact_err  in  1  factorial unit error (overflow or illegal n).
- fact_result  in  32  factorial unit result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_data  out  32  n! result.
- rsp_err  out  1  job ended with fact_err.
- rsp_timeout  out  1  job aborted by timeout.
- busy  out  1  high whenever state != IDLE.
- job_count  out  CNT_W  count of responses consumed.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, START, WAIT, RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in every other state req_ready SHALL be 0.
REQ-005 In IDLE with req_valid=1, req_n SHALL be latched into n_reg and the FSM SHALL move to START.
REQ-006 fact_n SHALL always drive n_reg, held stable from START through RESP.
REQ-007 In START, fact_go SHALL be 1 for exactly one cycle; the FSM SHALL then move to WAIT; fact_go SHALL be 0 in all other states.
REQ-008 On entry to WAIT, the timer SHALL be 0; it SHALL increment by 1 each cycle spent in WAIT.
REQ-009 In WAIT with fact_done=1 or fact_err=1:
- fact_err SHALL be captured into rsp_err.
- rsp_data SHALL capture fact_result when fact_err=0, else 0.
- rsp_timeout SHALL be cleared.
- the FSM SHALL move to RESP.
REQ-010 In WAIT with the timer equal to TIMEOUT_CYC-1 and fact_done=0 and fact_err=0:
- rsp_timeout SHALL be set to 1; rsp_data and rsp_err SHALL be set to 0.
- the FSM SHALL move to RESP.
REQ-011 When fact_done or fact_err coincides with timer expiry, completion SHALL win and rsp_timeout SHALL be 0.
REQ-012 fact_done and fact_err SHALL be ignored outside WAIT.
REQ-013 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_err and rsp_timeout SHALL be held stable until the handshake completes.
REQ-014 In RESP with rsp_ready=1, the FSM SHALL return to IDLE and job_count SHALL increment by 1, wrapping from all-ones to 0.
REQ-015 Timed-out and errored jobs SHALL be counted in job_count.
REQ-016 Latency: a request accepted at edge T SHALL produce fact_go in cycle T+1; if fact_done arrives in cycle T+1+k (k≥1), rsp_valid SHALL be high from cycle T+2+k.
REQ-017 A new request SHALL NOT be accepted in the cycle the response handshake completes; the earliest next acceptance is the following cycle in IDLE.

Reset
REQ-018 While rst=1, asynchronously and regardless of clk:
- state SHALL be IDLE.
- n_reg, the timer, rsp_data and job_count SHALL be 0.
- rsp_err, rsp_timeout, rsp_valid, fact_go and busy SHALL be 0.
- req_ready SHALL be 1.
REQ-019 Reset asserted mid-job (any state) SHALL discard the job with no response, and job_count SHALL read 0 after reset.

Verification
REQ-020 The bench SHALL cover these scenarios, with the factorial unit modelled as completing 2+n cycles after fact_go:
- req_n=5 → one fact_go pulse; rsp_data=120, rsp_err=0, rsp_timeout=0; job_count=1.
- req_n=0 then req_n=12 back-to-back → rsp_data=1, then rsp_data=479001600; job_count=2.
- req_n=13 with the model asserting fact_err → rsp_data=0, rsp_err=1.
- Model never asserts fact_done, TIMEOUT_CYC=8 → rsp_timeout=1 exactly 8 cycles after WAIT entry; rsp_data=0.
- req_n=4, rsp_ready held 0 for 10 cycles → rsp_valid and rsp_data=24 held stable; req_ready stays 0; completes when rsp_ready=1.
- rst pulsed during WAIT of an n=7 job → all outputs at reset values immediately; no rsp_valid; a following n=3 job returns 6.
